// File: rtl/net_activity_tx.sv
// Per-net toggle counter over fixed sampling windows; streams each window snapshot as (index, count) records.
// Optional header record with window sequence number: define NET_ACTIVITY_TX_HEADER_EN.
module net_activity_tx #(
    parameter int unsigned WIDTH  = 23,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned WINDOW = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] nets,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] out_data,
    output logic             out_last,
    output logic             overrun,
    output logic             overrun_s
);

    localparam int unsigned TMR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_SEND
    } state_t;

    if (WIDTH < 2) begin : g_chk_width
        $error("net_activity_tx: WIDTH must be at least 2");
    end
    if (WINDOW < WIDTH + 2) begin : g_chk_window
        $error("net_activity_tx: WINDOW must be at least WIDTH+2");
    end

    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] toggle;
    logic [CNT_W-1:0] live     [WIDTH];
    logic [CNT_W-1:0] live_nxt [WIDTH];
    logic [CNT_W-1:0] snap     [WIDTH];
    logic [TMR_W-1:0] timer;

    logic win_end;
    logic xfer;
    logic last_xfer;
    logic accept;
    logic drop;

    state_t           state;
    state_t           state_n;
    logic             valid_n;
    logic             last_n;
    logic [IDX_W-1:0] idx_n;
    logic [CNT_W-1:0] data_n;
    logic [IDX_W-1:0] nxt_idx;
    logic [CNT_W-1:0] nxt_data;

    // Toggles only count while enabled; prev still tracks so resume is clean.
    assign toggle = en ? (nets ^ prev) : '0;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            if (toggle[i] && (live[i] != CNT_MAX)) begin
                live_nxt[i] = live[i] + CNT_W'(1);
            end else begin
                live_nxt[i] = live[i];
            end
        end
    end

    assign win_end   = en && (timer == TMR_END);
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && out_last;
    // A new window is taken only if the link is free by the end of this cycle.
    assign accept    = win_end && ((state == S_IDLE) || last_xfer);
    assign drop      = win_end && !accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= '0;
            timer <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                live[i] <= '0;
                snap[i] <= '0;
            end
        end else begin
            prev <= nets;
            if (win_end) begin
                timer <= '0;
                for (int i = 0; i < WIDTH; i++) begin
                    live[i] <= '0;
                end
            end else begin
                if (en) begin
                    timer <= timer + TMR_W'(1);
                end
                for (int i = 0; i < WIDTH; i++) begin
                    live[i] <= live_nxt[i];
                end
            end
            if (accept) begin
                for (int i = 0; i < WIDTH; i++) begin
                    snap[i] <= live_nxt[i];
                end
            end
        end
    end

`ifdef NET_ACTIVITY_TX_HEADER_EN
    logic [CNT_W-1:0] win_seq;

    // Counts every window end, dropped or not; header carries the pre-increment value.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_seq <= '0;
        end else if (win_end) begin
            win_seq <= win_seq + CNT_W'(1);
        end
    end
`endif

    // Next record lookup; the header index (all ones) wraps to net 0.
    always_comb begin
        nxt_idx  = out_idx + IDX_W'(1);
        nxt_data = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (nxt_idx == IDX_W'(i)) begin
                nxt_data = snap[i];
            end
        end
    end

    always_comb begin
        state_n = state;
        valid_n = out_valid;
        idx_n   = out_idx;
        data_n  = out_data;
        last_n  = out_last;
        if (accept) begin
`ifdef NET_ACTIVITY_TX_HEADER_EN
            state_n = S_HDR;
            valid_n = 1'b1;
            idx_n   = '1;
            data_n  = win_seq;
            last_n  = 1'b0;
`else
            state_n = S_SEND;
            valid_n = 1'b1;
            idx_n   = '0;
            data_n  = live_nxt[0];
            last_n  = 1'b0;
`endif
        end else begin
            case (state)
                S_HDR, S_SEND: begin
                    if (xfer) begin
                        if (out_last) begin
                            state_n = S_IDLE;
                            valid_n = 1'b0;
                            last_n  = 1'b0;
                        end else begin
                            state_n = S_SEND;
                            idx_n   = nxt_idx;
                            data_n  = nxt_data;
                            last_n  = (nxt_idx == IDX_LAST);
                        end
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
            overrun_s <= 1'b0;
        end else begin
            state     <= state_n;
            out_valid <= valid_n;
            out_idx   <= idx_n;
            out_data  <= data_n;
            out_last  <= last_n;
            overrun   <= drop;
            if (drop) begin
                overrun_s <= 1'b1;
            end
        end
    end

endmodule
